// File: rtl/cache_writeback_queue.sv
// Writeback FIFO between the cache data store and the memory request port.
// Optional macro CS_WB_DROP_CLEAN_EN: accept all-zero-mask evictions without queueing them.
module cache_writeback_queue #(
  parameter int LINE_SIZE   = 16,
  parameter int ADDR_WIDTH  = 26,
  parameter int DEPTH       = 4,
  parameter int DIRTY_BYTES = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         evict_valid,
  input  logic [ADDR_WIDTH-1:0]        evict_addr,
  input  logic [LINE_SIZE*8-1:0]       evict_data,
  input  logic [LINE_SIZE-1:0]         evict_byteen,
  output logic                         evict_ready,
  output logic                         mem_req_valid,
  output logic                         mem_req_rw,
  output logic [ADDR_WIDTH-1:0]        mem_req_addr,
  output logic [LINE_SIZE*8-1:0]       mem_req_data,
  output logic [LINE_SIZE-1:0]         mem_req_byteen,
  input  logic                         mem_req_ready,
  input  logic [ADDR_WIDTH-1:0]        lookup_addr,
  output logic                         lookup_hit,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready;
  // valid never depends on ready, and evict_ready depends only on registered count.

  localparam int DATA_W = LINE_SIZE * 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [DEPTH-1:0]      r_valid;
  logic [ADDR_WIDTH-1:0] r_addr   [DEPTH];
  logic [DATA_W-1:0]     r_data   [DEPTH];
  logic [LINE_SIZE-1:0]  r_byteen [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_push_acc;
  logic w_clean;
  logic w_store;
  logic w_pop;
  logic w_lookup_hit;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  assign w_push_acc = evict_valid && !w_full && !reset;

`ifdef CS_WB_DROP_CLEAN_EN
  // A line with no dirty bytes has nothing to write back; swallow it.
  assign w_clean = (DIRTY_BYTES != 0) && (evict_byteen == '0);
`else
  assign w_clean = 1'b0;
`endif

  assign w_store = w_push_acc && !w_clean;
  assign w_pop   = !w_empty && mem_req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
      end
      // Store and pop never target the same slot: that would need full and empty at once.
      if (w_store) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_addr[r_wr_ptr]   <= evict_addr;
      r_data[r_wr_ptr]   <= evict_data;
      r_byteen[r_wr_ptr] <= evict_byteen;
    end
  end

  // Only registered valid bits participate, so a same-cycle push never hits.
  always_comb begin
    w_lookup_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i] == lookup_addr)) begin
        w_lookup_hit = 1'b1;
      end
    end
  end

  assign evict_ready    = !w_full;
  assign mem_req_valid  = !w_empty;
  assign mem_req_rw     = 1'b1;
  assign mem_req_addr   = r_addr[r_rd_ptr];
  assign mem_req_data   = r_data[r_rd_ptr];
  assign mem_req_byteen = (DIRTY_BYTES != 0) ? r_byteen[r_rd_ptr] : {LINE_SIZE{1'b1}};
  assign lookup_hit     = w_lookup_hit;
  assign empty          = w_empty;
  assign full           = w_full;
  assign count          = r_count;

endmodule
